// File: rtl/apb_mem_slave_ws.sv
// APB4 scratch memory slave with configurable wait states, byte-lane strobe merging,
// error decode (misaligned / out of range / privileged write / strobed read) and error counter.
module apb_mem_slave_ws #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_CYCLES = 0,
    parameter int PRIV_BASE   = MEM_DEPTH
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic [7:0]              err_cnt
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int AL  = $clog2(NB);
    localparam int IW  = ADDR_WIDTH - AL;
    localparam int MAW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [MAW-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]         strb_q, strb_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [IW-1:0]  addr_idx;
    logic [MAW-1:0] mem_idx;
    logic           misaligned, out_of_range, in_priv, setup_err;
    logic           rd_load, rd_clear, mem_we;

    assign addr_idx     = PADDR[ADDR_WIDTH-1:AL];
    assign mem_idx      = addr_idx[MAW-1:0];
    assign misaligned   = |PADDR[AL-1:0];
    assign out_of_range = 64'(addr_idx) >= 64'(MEM_DEPTH);
    assign in_priv      = 64'(addr_idx) >= 64'(PRIV_BASE);
    assign setup_err    = misaligned | out_of_range
                        | (PWRITE & in_priv & ~PPROT[0])
                        | (~PWRITE & (|PSTRB));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        err_d     = err_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        err_cnt_d = err_cnt_q;
        rd_load   = 1'b0;
        rd_clear  = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d  = ACCESS;
                    write_d  = PWRITE;
                    idx_d    = mem_idx;
                    wdata_d  = PWDATA;
                    strb_d   = PSTRB;
                    err_d    = setup_err;
                    cnt_d    = 4'(WAIT_CYCLES);
                    rd_load  = !PWRITE && !setup_err;
                    rd_clear = !PWRITE && setup_err;
                    if (WAIT_CYCLES == 0) begin
                        pready_d  = 1'b1;
                        pslverr_d = setup_err;
                    end
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    // Master abandoned the transfer: drop it without committing.
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end else if (pready_q) begin
                    mem_we = write_q && !err_q;
                    if (err_q && err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            write_q   <= write_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // One byte-wide RAM per lane so strobed writes need no read-modify-write.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] mem [MEM_DEPTH];

            always_ff @(posedge PCLK) begin
                if (mem_we && !PRESET && strb_q[gi]) begin
                    mem[idx_q] <= wdata_q[gi*8 +: 8];
                end
            end

            always_ff @(posedge PCLK) begin
                if (PRESET) begin
                    rdata_q[gi*8 +: 8] <= '0;
                end else if (rd_load) begin
                    rdata_q[gi*8 +: 8] <= mem[mem_idx];
                end else if (rd_clear) begin
                    rdata_q[gi*8 +: 8] <= '0;
                end
            end
        end
    endgenerate

    assign PRDATA  = rdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_apb_mem_slave_ws.sv
// Directed bench for apb_mem_slave_ws: three instances with 0, 3 and 2 wait states.
module tb_apb_mem_slave_ws;
    logic        clk, preset;
    logic [2:0]  psel;
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];
    logic [7:0]  err_cnt [3];

    int vectors = 0;
    int miscompares = 0;
    int wc_of [3] = '{0, 3, 2};
    int exp_cnt [3] = '{0, 0, 0};
    logic        scramble = 1'b0;
    logic [31:0] alt_addr = 32'h0;

    apb_mem_slave_ws #(.WAIT_CYCLES(0), .PRIV_BASE(512)) u_ws0 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]), .err_cnt(err_cnt[0]));
    apb_mem_slave_ws #(.WAIT_CYCLES(3)) u_ws3 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]), .err_cnt(err_cnt[1]));
    apb_mem_slave_ws #(.WAIT_CYCLES(2)) u_ws2 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]), .err_cnt(err_cnt[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input logic [2:0] prot,
                        output logic [31:0] rd, output logic er, output int nacc);
        psel = 3'b000; psel[d] = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb; pprot = prot;
        @(posedge clk); #1;
        penable = 1'b1;
        if (scramble) begin
            paddr = alt_addr; pwdata = ~wd; pprot = ~prot;
        end
        nacc = 1;
        while (pready[d] !== 1'b1 && nacc < 40) begin
            @(posedge clk); #1;
            nacc++;
        end
        if (pready[d] !== 1'b1) chk("pready_timeout", 32'(pready[d]), 32'd1);
        rd = prdata[d];
        er = pslverr[d];
        @(posedge clk); #1;
        psel = 3'b000; penable = 1'b0;
        $display("xfer dut=%0d wr=%0b addr=%h wdata=%h strb=%h prot=%0d -> rdata=%h slverr=%0b acc_cycles=%0d",
                 d, wr, addr, wd, strb, prot, rd, er, nacc);
    endtask

    task automatic finish_chk(input string tag, input int d, input logic er, input int n, input logic exp_err);
        chk({tag, "_slverr"}, 32'(er), 32'(exp_err));
        chk({tag, "_cycles"}, 32'(n), 32'(wc_of[d] + 1));
        if (exp_err && exp_cnt[d] < 255) exp_cnt[d]++;
        chk({tag, "_errcnt"}, 32'(err_cnt[d]), 32'(exp_cnt[d]));
    endtask

    task automatic wr_chk(input string tag, input int d, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, input logic [2:0] prot, input logic exp_err);
        logic [31:0] rd; logic er; int n;
        xfer(d, 1'b1, addr, wd, strb, prot, rd, er, n);
        finish_chk(tag, d, er, n, exp_err);
    endtask

    task automatic rd_chk(input string tag, input int d, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [2:0] prot, input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] rd; logic er; int n;
        xfer(d, 1'b0, addr, 32'h0, strb, prot, rd, er, n);
        chk({tag, "_rdata"}, rd, exp_data);
        finish_chk(tag, d, er, n, exp_err);
    endtask

    initial begin
        logic [31:0] rd; logic er; int n;
        preset = 1'b1; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        repeat (3) @(posedge clk);
        #1 preset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk("reset_prdata", prdata[d], 32'h0);
            chk("reset_pready", 32'(pready[d]), 32'h0);
            chk("reset_pslverr", 32'(pslverr[d]), 32'h0);
            chk("reset_errcnt", 32'(err_cnt[d]), 32'h0);
        end

        // Zero-wait write/read, back to back
        wr_chk("wr_beef", 0, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 1'b0);
        rd_chk("rd_beef", 0, 32'h10, 4'h0, 3'd0, 32'hDEADBEEF, 1'b0);

        // Strobe merging
        wr_chk("sm_full", 0, 32'h20, 32'h11223344, 4'hF, 3'd0, 1'b0);
        wr_chk("sm_part", 0, 32'h20, 32'hAABBCCDD, 4'h5, 3'd0, 1'b0);
        rd_chk("sm_rd", 0, 32'h20, 4'h0, 3'd0, 32'h11BB33DD, 1'b0);
        wr_chk("sm_zero", 0, 32'h20, 32'hFFFFFFFF, 4'h0, 3'd0, 1'b0);
        rd_chk("sm_rd2", 0, 32'h20, 4'h0, 3'd0, 32'h11BB33DD, 1'b0);

        // Error decode
        rd_chk("e_misal", 0, 32'h12, 4'h0, 3'd0, 32'h0, 1'b1);
        rd_chk("e_rdstrb", 0, 32'h10, 4'h1, 3'd0, 32'h0, 1'b1);
        wr_chk("e_pre0", 0, 32'h0, 32'h01020304, 4'hF, 3'd0, 1'b0);
        wr_chk("e_oor", 0, 32'h1000, 32'hFFFFFFFF, 4'hF, 3'd0, 1'b1);
        rd_chk("e_oor_rd", 0, 32'h0, 4'h0, 3'd0, 32'h01020304, 1'b0);
        wr_chk("p_below", 0, 32'h7FC, 32'h77777777, 4'hF, 3'd0, 1'b0);
        rd_chk("p_below_rd", 0, 32'h7FC, 4'h0, 3'd0, 32'h77777777, 1'b0);
        wr_chk("p_ok1", 0, 32'h800, 32'hA5A5A5A5, 4'hF, 3'd1, 1'b0);
        wr_chk("p_err", 0, 32'h800, 32'h5A5A5A5A, 4'hF, 3'd0, 1'b1);
        rd_chk("p_rd1", 0, 32'h800, 4'h0, 3'd0, 32'hA5A5A5A5, 1'b0);
        wr_chk("p_ok2", 0, 32'h800, 32'h5A5A5A5A, 4'hF, 3'd1, 1'b0);
        rd_chk("p_rd2", 0, 32'h800, 4'h0, 3'd0, 32'h5A5A5A5A, 1'b0);

        // Three wait states; access-phase bus changes must be ignored
        wr_chk("w3_a", 1, 32'h30, 32'h55AA55AA, 4'hF, 3'd0, 1'b0);
        wr_chk("w3_b", 1, 32'h34, 32'h12345678, 4'hF, 3'd0, 1'b0);
        scramble = 1'b1; alt_addr = 32'h34;
        rd_chk("w3_rd", 1, 32'h30, 4'h0, 3'd0, 32'h55AA55AA, 1'b0);
        wr_chk("w3_wscr", 1, 32'h38, 32'h0F0F0F0F, 4'hF, 3'd0, 1'b0);
        scramble = 1'b0;
        rd_chk("w3_rd34", 1, 32'h34, 4'h0, 3'd0, 32'h12345678, 1'b0);
        rd_chk("w3_rd38", 1, 32'h38, 4'h0, 3'd0, 32'h0F0F0F0F, 1'b0);

        // Abort in second access cycle of a two-wait write
        wr_chk("ab_pre", 2, 32'h50, 32'h0BADF00D, 4'hF, 3'd0, 1'b0);
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h50;
        pwdata = 32'hFFFFFFFF; pstrb = 4'hF; pprot = 3'd0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 3'b000; penable = 1'b0;
        @(posedge clk); #1;
        chk("ab_pready", 32'(pready[2]), 32'h0);
        $display("xfer dut=2 aborted write addr=00000050");
        rd_chk("ab_rd", 2, 32'h50, 4'h0, 3'd0, 32'h0BADF00D, 1'b0);

        // Reset mid-wait
        rd_chk("rs_err", 1, 32'h41, 4'h0, 3'd0, 32'h0, 1'b1);
        rd_chk("rs_prime", 1, 32'h30, 4'h0, 3'd0, 32'h55AA55AA, 1'b0);
        psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30;
        pwdata = 32'h0; pstrb = 4'hF; pprot = 3'd0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 preset = 1'b1; psel = 3'b000; penable = 1'b0;
        @(posedge clk); #1 preset = 1'b0;
        $display("xfer dut=1 write addr=00000030 interrupted by reset");
        chk("rs_prdata", prdata[1], 32'h0);
        chk("rs_pready", 32'(pready[1]), 32'h0);
        chk("rs_pslverr", 32'(pslverr[1]), 32'h0);
        chk("rs_errcnt", 32'(err_cnt[1]), 32'h0);
        exp_cnt = '{0, 0, 0};
        rd_chk("rs_rd", 1, 32'h30, 4'h0, 3'd0, 32'h55AA55AA, 1'b0);

        // Saturation
        for (int i = 0; i < 300; i++) begin
            xfer(0, 1'b0, 32'h13, 32'h0, 4'h0, 3'd0, rd, er, n);
        end
        chk("sat_errcnt", 32'(err_cnt[0]), 32'd255);
        exp_cnt[0] = 255;
        rd_chk("sat_more", 0, 32'h11, 4'h0, 3'd0, 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
